complex_multiplier: RTL and testbench

COMPLEX_MULTIPLIER -- requirements
Module: complex_multiplier

---
 rtl/complex_multiplier.sv | 87 ++++++++
 tb/tb_complex_multiplier.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/complex_multiplier.sv
// Purpose: signed complex multiply, (ar + j*ai) * (br + j*bi), at full precision.
// Latency: one clock; inputs sampled at a rising edge appear on the outputs right after it.
// Backpressure: none; accepts a new operand pair every clock with no handshake.
module complex_multiplier #(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 18,
    // Must be at least A_WIDTH+B_WIDTH+1 so the sum/difference of two
    // full-precision products can never overflow.
    parameter int OUT_WIDTH = A_WIDTH + B_WIDTH + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [A_WIDTH-1:0]   real_part_a,
    input  logic signed [A_WIDTH-1:0]   imag_part_a,
    input  logic signed [B_WIDTH-1:0]   real_part_b,
    input  logic signed [B_WIDTH-1:0]   imag_part_b,
    output logic signed [OUT_WIDTH-1:0] real_output,
    output logic signed [OUT_WIDTH-1:0] imag_output
);

    // Width of one full-precision partial product.
    localparam int P_WIDTH = A_WIDTH + B_WIDTH;
    // Extra sign bits needed to carry a partial product up to output width.
    localparam int X_WIDTH = OUT_WIDTH - P_WIDTH;

    // Operands sign-extended to product width so every multiply is
    // same-width signed and its low P_WIDTH bits are the exact product.
    logic signed [P_WIDTH-1:0]   w_ar;
    logic signed [P_WIDTH-1:0]   w_ai;
    logic signed [P_WIDTH-1:0]   w_br;
    logic signed [P_WIDTH-1:0]   w_bi;

    // Four full-precision partial products.
    logic signed [P_WIDTH-1:0]   w_p_rr;
    logic signed [P_WIDTH-1:0]   w_p_ii;
    logic signed [P_WIDTH-1:0]   w_p_ri;
    logic signed [P_WIDTH-1:0]   w_p_ir;

    // Partial products sign-extended to output width before combining.
    logic signed [OUT_WIDTH-1:0] w_x_rr;
    logic signed [OUT_WIDTH-1:0] w_x_ii;
    logic signed [OUT_WIDTH-1:0] w_x_ri;
    logic signed [OUT_WIDTH-1:0] w_x_ir;

    // Next-state values for the output registers.
    logic signed [OUT_WIDTH-1:0] w_real_nxt;
    logic signed [OUT_WIDTH-1:0] w_imag_nxt;

    // Output registers; the ports are driven from these and nothing else.
    logic signed [OUT_WIDTH-1:0] r_real;
    logic signed [OUT_WIDTH-1:0] r_imag;

    assign w_ar = {{B_WIDTH{real_part_a[A_WIDTH-1]}}, real_part_a};
    assign w_ai = {{B_WIDTH{imag_part_a[A_WIDTH-1]}}, imag_part_a};
    assign w_br = {{A_WIDTH{real_part_b[B_WIDTH-1]}}, real_part_b};
    assign w_bi = {{A_WIDTH{imag_part_b[B_WIDTH-1]}}, imag_part_b};

    assign w_p_rr = w_ar * w_br;
    assign w_p_ii = w_ai * w_bi;
    assign w_p_ri = w_ar * w_bi;
    assign w_p_ir = w_ai * w_br;

    assign w_x_rr = {{X_WIDTH{w_p_rr[P_WIDTH-1]}}, w_p_rr};
    assign w_x_ii = {{X_WIDTH{w_p_ii[P_WIDTH-1]}}, w_p_ii};
    assign w_x_ri = {{X_WIDTH{w_p_ri[P_WIDTH-1]}}, w_p_ri};
    assign w_x_ir = {{X_WIDTH{w_p_ir[P_WIDTH-1]}}, w_p_ir};

    // Combine at output width: no truncation, rounding or saturation.
    assign w_real_nxt = w_x_rr - w_x_ii;
    assign w_imag_nxt = w_x_ri + w_x_ir;

    // Register the result every clock; synchronous reset clears it and
    // discards whatever product was being computed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_real <= '0;
            r_imag <= '0;
        end else begin
            r_real <= w_real_nxt;
            r_imag <= w_imag_nxt;
        end
    end

    assign real_output = r_real;
    assign imag_output = r_imag;

endmodule

// File: tb/tb_complex_multiplier.sv
// Directed bench for complex_multiplier at default widths.
module tb_complex_multiplier;

    localparam int AW = 16;
    localparam int BW = 18;
    localparam int OW = 35;

    logic                 clk;
    logic                 rst;
    logic signed [AW-1:0] real_part_a;
    logic signed [AW-1:0] imag_part_a;
    logic signed [BW-1:0] real_part_b;
    logic signed [BW-1:0] imag_part_b;
    logic signed [OW-1:0] real_output;
    logic signed [OW-1:0] imag_output;

    int total;
    int bad;

    complex_multiplier #(
        .A_WIDTH  (AW),
        .B_WIDTH  (BW),
        .OUT_WIDTH(OW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .real_part_a(real_part_a),
        .imag_part_a(imag_part_a),
        .real_part_b(real_part_b),
        .imag_part_b(imag_part_b),
        .real_output(real_output),
        .imag_output(imag_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact arithmetic in 64 bits, then the 35-bit encoding.
    function automatic logic [OW-1:0] ref_re(input logic signed [AW-1:0] ar, input logic signed [AW-1:0] ai,
                                             input logic signed [BW-1:0] br, input logic signed [BW-1:0] bi);
        longint p;
        p = longint'(ar) * longint'(br) - longint'(ai) * longint'(bi);
        return p[OW-1:0];
    endfunction

    function automatic logic [OW-1:0] ref_im(input logic signed [AW-1:0] ar, input logic signed [AW-1:0] ai,
                                             input logic signed [BW-1:0] br, input logic signed [BW-1:0] bi);
        longint p;
        p = longint'(ar) * longint'(bi) + longint'(ai) * longint'(br);
        return p[OW-1:0];
    endfunction

    task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic signed [AW-1:0] ar, input logic signed [AW-1:0] ai,
                         input logic signed [BW-1:0] br, input logic signed [BW-1:0] bi);
        real_part_a = ar;
        imag_part_a = ai;
        real_part_b = br;
        imag_part_b = bi;
    endtask

    // Advance one rising edge and settle just past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic signed [AW-1:0] sar, sai;
        logic signed [BW-1:0] sbr, sbi;
        logic [OW-1:0] er, ei;
        total = 0;
        bad   = 0;

        // Reset hold for two edges with a live operand pair present.
        rst = 1'b1;
        drive(16'sd3, 16'sd4, 18'sd5, 18'sd2);
        tick();
        check("rst_hold1_re", real_output, 35'd0);
        check("rst_hold1_im", imag_output, 35'd0);
        tick();
        check("rst_hold2_re", real_output, 35'd0);
        check("rst_hold2_im", imag_output, 35'd0);

        // First edge out of reset: (3+4j)(5+2j) = 7 + 26j.
        rst = 1'b0;
        tick();
        check("basic_re", real_output, 35'd7);
        check("basic_im", imag_output, 35'd26);

        // Change inputs mid-cycle: outputs must hold until the next edge.
        drive(16'sd1, 16'sd8, 18'sd2, 18'sd3);
        #3;
        check("hold_re", real_output, 35'd7);
        check("hold_im", imag_output, 35'd26);

        // (1+8j)(2+3j) = -22 + 19j.
        tick();
        check("neg_re", real_output, 35'h7_FFFF_FFEA);
        check("neg_im", imag_output, 35'd19);

        // (-32768-32768j)(-131072-131072j) = 0 + 2^33 j.
        drive(-16'sd32768, -16'sd32768, -18'sd131072, -18'sd131072);
        tick();
        check("ext1_re", real_output, 35'd0);
        check("ext1_im", imag_output, 35'd8589934592);

        // (-32768-32768j)(-131072+131071j):
        //   re = 2^32 + 32768*131071 = 8589901824
        //   im = -32768*131071 + 32768*131072 = 32768
        drive(-16'sd32768, -16'sd32768, -18'sd131072, 18'sd131071);
        tick();
        check("ext2_re", real_output, 35'd8589901824);
        check("ext2_im", imag_output, 35'd32768);

        // Back-to-back random stream with a one-edge reset in the middle.
        for (int i = 0; i < 120; i++) begin
            sar = AW'($urandom);
            sai = AW'($urandom);
            sbr = BW'($urandom);
            sbi = BW'($urandom);
            drive(sar, sai, sbr, sbi);
            rst = (i == 60);
            tick();
            if (i == 60) begin
                check("midrst_re", real_output, 35'd0);
                check("midrst_im", imag_output, 35'd0);
            end else begin
                er = ref_re(sar, sai, sbr, sbi);
                ei = ref_im(sar, sai, sbr, sbi);
                check("stream_re", real_output, er);
                check("stream_im", imag_output, ei);
            end
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
